// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises and de-glitches the keyboard lines, decodes
// 11-bit frames, and tracks E0/F0 prefixes to report make codes and releases.
module ps2_keyboard_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk100MHz,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       newKeyStrobe,
  output logic       extended,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clk_sync, data_sync;
  logic          filt_clk, fall_edge;
  logic [FW-1:0] filt_cnt;
  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_ok_q, parity_ok_d;
  logic [TW-1:0] timeout_q, timeout_d;
  logic          byte_done, frame_bad;
  logic          ext_pending, break_pending;
  logic          data_s;

  assign data_s = data_sync[1];

  // Synchronisers idle high so reset release never looks like a falling edge.
  always_ff @(posedge clk100MHz or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // The filtered clock flips only after FILTER_LEN consecutive differing samples;
  // fall_edge is high in the cycle the filtered clock becomes 0.
  always_ff @(posedge clk100MHz or negedge reset_n) begin
    if (!reset_n) begin
      filt_clk  <= 1'b1;
      filt_cnt  <= '0;
      fall_edge <= 1'b0;
    end else begin
      fall_edge <= 1'b0;
      if (clk_sync[1] != filt_clk) begin
        if (filt_cnt == FW'(FILTER_LEN - 1)) begin
          filt_clk  <= clk_sync[1];
          filt_cnt  <= '0;
          fall_edge <= filt_clk;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_ok_q <= 1'b0;
      timeout_q   <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_ok_q <= parity_ok_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    // NOTE: every variable is defaulted first so no path through the block infers a latch.
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_ok_d = parity_ok_q;
    byte_done   = 1'b0;
    frame_bad   = 1'b0;
    timeout_d   = (state_q == IDLE || fall_edge) ? '0 : timeout_q + 1'b1;

    if (state_q != IDLE && !fall_edge && timeout_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d   = IDLE;
      frame_bad = 1'b1;
      timeout_d = '0;
    end else if (fall_edge) begin
      case (state_q)
        IDLE: if (!data_s) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
        DATA: begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          parity_ok_d = ^{shift_q, data_s};
          state_d     = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (data_s && parity_ok_q) byte_done = 1'b1;
          else                       frame_bad = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Scan-code layer: prefixes only arm flags; a release clears keycode only when
  // it names the key currently held.
  always_ff @(posedge clk100MHz or negedge reset_n) begin
    if (!reset_n) begin
      keycode       <= 8'h00;
      extended      <= 1'b0;
      newKeyStrobe  <= 1'b0;
      frame_err     <= 1'b0;
      ext_pending   <= 1'b0;
      break_pending <= 1'b0;
    end else begin
      newKeyStrobe <= 1'b0;
      frame_err    <= 1'b0;
      if (frame_bad) begin
        frame_err     <= 1'b1;
        ext_pending   <= 1'b0;
        break_pending <= 1'b0;
      end else if (byte_done) begin
        if (shift_q == 8'hE0) begin
          ext_pending <= 1'b1;
        end else if (shift_q == 8'hF0) begin
          break_pending <= 1'b1;
        end else begin
          if (!break_pending) begin
            keycode      <= shift_q;
            extended     <= ext_pending;
            newKeyStrobe <= 1'b1;
          end else if (shift_q == keycode && ext_pending == extended) begin
            keycode  <= 8'h00;
            extended <= 1'b0;
          end
          ext_pending   <= 1'b0;
          break_pending <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx: drives PS/2 frames and compares every
// strobe against a scoreboard of expected {extended, keycode} pairs.
module tb_ps2_keyboard_rx;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 400;
  localparam int HALF           = 20;

  logic       clk100MHz = 1'b0;
  logic       reset_n   = 1'b0;
  logic       ps2_clk   = 1'b1;
  logic       ps2_data  = 1'b1;
  logic [7:0] keycode;
  logic       newKeyStrobe, extended, frame_err;

  ps2_keyboard_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk100MHz   (clk100MHz),
    .reset_n     (reset_n),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .keycode     (keycode),
    .newKeyStrobe(newKeyStrobe),
    .extended    (extended),
    .frame_err   (frame_err)
  );

  always #5 clk100MHz = ~clk100MHz;

  int         n_checks   = 0;
  int         n_errors   = 0;
  int         strobe_cnt = 0;
  int         err_cnt    = 0;
  logic       prev_strobe = 1'b0;
  logic       prev_err    = 1'b0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk100MHz);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(1'b1);
    ps2_data = 1'b1;
    wait_cyc(40);
  endtask

  task automatic send_make(input logic [7:0] b, input logic ext);
    exp_q.push_back({ext, b});
    send_frame(b, 1'b0);
  endtask

  // Monitor: sampled on the falling clock edge, away from the DUT's active edge.
  always @(negedge clk100MHz) begin
    if (newKeyStrobe) begin
      strobe_cnt++;
      check("strobe_width", prev_strobe, 0);
      check("strobe_and_err", frame_err, 0);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", newKeyStrobe, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_keycode", keycode, mon_e[7:0]);
        check("sb_extended", extended, mon_e[8]);
      end
    end
    if (frame_err) begin
      err_cnt++;
      check("err_width", prev_err, 0);
    end
    prev_strobe = newKeyStrobe;
    prev_err    = frame_err;
  end

  initial begin
    wait_cyc(3);
    check("rst_keycode", keycode, 8'h00);
    check("rst_strobe", newKeyStrobe, 0);
    check("rst_extended", extended, 0);
    check("rst_frame_err", frame_err, 0);
    reset_n = 1'b1;
    wait_cyc(20);
    check("no_edge_after_rst", strobe_cnt + err_cnt, 0);

    send_make(8'h1B, 1'b0);
    check("make_1b_cnt", strobe_cnt, 1);
    check("make_1b_kc", keycode, 8'h1B);

    send_frame(8'hE0, 1'b0);
    check("e0_no_strobe", strobe_cnt, 1);
    send_make(8'h75, 1'b1);
    check("ext_cnt", strobe_cnt, 2);
    check("ext_kc", keycode, 8'h75);
    check("ext_flag", extended, 1);

    send_make(8'h1B, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h2D, 1'b0);
    check("other_break_kc", keycode, 8'h1B);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1B, 1'b0);
    check("break_kc", keycode, 8'h00);
    check("break_ext", extended, 0);
    check("break_cnt", strobe_cnt, 3);

    send_make(8'h1C, 1'b0);
    send_make(8'h1C, 1'b0);
    check("typematic_cnt", strobe_cnt, 5);

    send_frame(8'h4D, 1'b1);
    check("parity_err", err_cnt, 1);
    check("parity_no_strobe", strobe_cnt, 5);
    check("parity_kc_held", keycode, 8'h1C);
    send_make(8'h4D, 1'b0);
    check("after_err_kc", keycode, 8'h4D);

    send_frame(8'hF0, 1'b0);
    send_frame(8'h3C, 1'b1);
    send_make(8'h3C, 1'b0);
    check("err_clears_break", keycode, 8'h3C);
    check("err_clears_cnt", err_cnt, 2);

    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    wait_cyc(TIMEOUT_CYCLES + 50);
    check("timeout_err", err_cnt, 3);
    send_make(8'h2D, 1'b0);
    check("after_timeout_kc", keycode, 8'h2D);

    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    reset_n = 1'b0;
    wait_cyc(1);
    check("midrst_keycode", keycode, 8'h00);
    check("midrst_extended", extended, 0);
    wait_cyc(2);
    reset_n  = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(20);
    check("midrst_no_err", err_cnt, 3);
    send_make(8'h76, 1'b0);
    check("after_rst_kc", keycode, 8'h76);
    check("after_rst_cnt", strobe_cnt, 9);

    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    wait_cyc(FILTER_LEN - 3);
    ps2_clk  = 1'b1;
    wait_cyc(30);
    ps2_data = 1'b1;
    wait_cyc(10);
    send_make(8'h3A, 1'b0);
    check("glitch_kc", keycode, 8'h3A);
    check("glitch_no_err", err_cnt, 3);
    check("glitch_cnt", strobe_cnt, 10);

    check("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_rx.md
PS2_KEYBOARD_RX -- requirements
Module: ps2_keyboard_rx

Interface
REQ-001 Parameter FILTER_LEN, default 8: consecutive identical synchronized samples required before the filtered ps2_clk changes value.
REQ-002 Parameter TIMEOUT_CYCLES, default 200000: idle clocks allowed between ps2_clk falling edges inside a frame (2 ms at 100 MHz).
REQ-003 clk100MHz  input  1  system clock; all logic on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 ps2_clk  input  1  keyboard clock, asynchronous to clk100MHz.
REQ-006 ps2_data  input  1  keyboard data, asynchronous to clk100MHz.
REQ-007 keycode  output  8  last make scan code; held until replaced or released.
REQ-008 newKeyStrobe  output  1  one-cycle pulse per accepted make code.
REQ-009 extended  output  1  1 when the current keycode was prefixed by 0xE0.
REQ-010 frame_err  output  1  one-cycle pulse per discarded frame.

Function
REQ-011 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer before any use.
REQ-012 Filtered clock SHALL change only after FILTER_LEN consecutive equal synchronized samples; falling edge = filtered 1->0.
REQ-013 Frame SHALL be 11 bits sampled on filtered falling edges: start 0, 8 data LSB first, odd parity, stop 1.
REQ-014 FSM states SHALL be IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: falling edge with data 0 -> DATA with bit count 0; data 1 -> stay in IDLE, no error.
REQ-016 DATA: each edge shifts data into the MSB of an 8-bit register (shift right); the 8th bit -> PARITY.
REQ-017 PARITY: sample parity bit -> STOP; parity OK iff XOR of 8 data bits and parity bit = 1.
REQ-018 STOP: sample stop bit -> IDLE; stop=1 and parity OK -> byte valid; otherwise pulse frame_err and discard the byte.
REQ-019 Timeout counter SHALL clear on every falling edge and in IDLE; in any non-IDLE state, reaching TIMEOUT_CYCLES -> IDLE plus frame_err pulse.
REQ-020 Any frame_err SHALL clear ext_pending and break_pending.
REQ-021 Valid byte 0xE0 SHALL set ext_pending, with no output change.
REQ-022 Valid byte 0xF0 SHALL set break_pending, with no output change.
REQ-023 Other valid byte with break_pending=0: keycode<=byte, extended<=ext_pending, newKeyStrobe pulses; both pending flags clear.
REQ-024 Other valid byte with break_pending=1: no strobe; if byte==keycode and ext_pending==extended, keycode<=0x00 and extended<=0; otherwise outputs unchanged; both flags clear.
REQ-025 newKeyStrobe SHALL assert exactly 1 clock after the cycle in which the stop-bit falling edge is detected; keycode/extended SHALL be valid in that same cycle.
REQ-026 Repeated make codes (typematic) SHALL each produce a strobe, including a repeat of an identical code.
REQ-027 newKeyStrobe and frame_err SHALL never be high in the same cycle and SHALL never exceed one cycle wide.
REQ-028 No host-to-device transmission; ps2_clk and ps2_data are input only.

Reset
REQ-029 reset_n=0 SHALL immediately force: keycode=0x00, newKeyStrobe=0, extended=0, frame_err=0, state IDLE, flags, bit count, shift register and timeout counter 0.
REQ-030 During reset, synchronizer and filter flops SHALL reset to 1 (idle bus high), so the release of reset causes no false falling edge.
REQ-031 Reset asserted mid-frame SHALL abandon the frame with no strobe and no frame_err.

Verification
REQ-032 Frame 0x1B (parity 1) -> keycode=0x1B, extended=0, newKeyStrobe high for exactly 1 cycle.
REQ-033 Frames E0, 75 -> a single strobe after 0x75 only; keycode=0x75, extended=1.
REQ-034 Make 1B, then F0, 1B -> one strobe total; keycode=0x00 after the release; F0, 2D while 1B is held -> keycode stays 0x1B.
REQ-035 Frame 0x4D with parity 0 -> frame_err pulse, no strobe, keycode unchanged; a following good 0x4D -> strobe, keycode=0x4D.
REQ-036 Start plus 5 data bits, then TIMEOUT_CYCLES idle clocks -> frame_err pulse, FSM in IDLE; a next good 0x2D -> keycode=0x2D.
REQ-037 reset_n low for 3 cycles mid-frame, then a good 0x76 -> outputs 0 during reset, then keycode=0x76 with one strobe; ps2_clk glitch shorter than FILTER_LEN -> no edge detected.
